uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver: configurable data width, parity, stop bits, 3-sample majority voting.
//  Reports parity and framing errors alongside each received word.
//  Sits between the async serial pin and the command decoder; one word out per frame, no buffering.
// PARAMETERS
//  CLKS_PER_BIT  16  clocks per bit; must be >= 4
//  DATA_BITS     8   data bits per frame, 5..9, sent LSB first
//  PARITY        0   parity mode: 0 none, 1 odd, 2 even
//  STOP_BITS     1   stop bits, 1 or 2
// PORTS
//  i_Clock      in   1          system clock; all logic on its rising edge
//  i_Reset_n    in   1          synchronous, active-low reset
//  i_Rx_Serial  in   1          async serial line, idle high
//  o_Rx_DV      out  1          1-cycle strobe: word and error flags valid
//  o_Rx_Byte    out  DATA_BITS  received word; held until next o_Rx_DV
//  o_Parity_Err out  1          parity mismatch on last word; 0 when PARITY=0; held until next o_Rx_DV
//  o_Frame_Err  out  1          any stop bit sampled 0 on last word; held until next o_Rx_DV
//  o_Busy       out  1          1 in any state other than IDLE
//  o_Break      out  1          1-cycle break strobe (UART_RX_BREAK_DETECT_EN only; else constant 0)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; both sync FFs 1; counters 0. Reset mid-frame aborts it, no o_Rx_DV.
//  Input sync: 2-FF synchroniser; all decisions use the second stage (S).
//  Bit timing: counter C runs 0..CLKS_PER_BIT-1 per bit, width $clog2(CLKS_PER_BIT); M = CLKS_PER_BIT/2.
//  Sampling: S captured at C = M-1, M, M+1; bit value = majority of the 3 samples.
//  States:
//   IDLE: C=0. S==0 and armed -> START.
//   START: at C=M+1, majority 1 -> IDLE (false start, no strobe).
//     C=CLKS_PER_BIT-1 -> DATA.
//   DATA: store majority into bit index i at C=M+1. Bits are LSB first.
//     At C=CLKS_PER_BIT-1: i==DATA_BITS-1 -> PARITY (PARITY!=0) or STOP; else i+1.
//   PARITY: majority compared with XOR of data (odd: expect ~XOR; even: expect XOR). Full bit, then STOP.
//   STOP: each stop bit voted at C=M+1; any 0 sets frame error.
//     Non-last stop bit runs full period.
//     Last stop bit leaves at C=M+1 (mid-bit, allows back-to-back frames) -> CLEANUP.
//   CLEANUP: register o_Rx_Byte, o_Parity_Err, o_Frame_Err; o_Rx_DV=1 for this one cycle; -> IDLE.
//  Latency: o_Rx_DV rises ~ (1+DATA_BITS+P+STOP_BITS-0.5)*CLKS_PER_BIT + 4 clocks after start edge at pin (P=1 if parity).
//  Re-arm: after a frame with o_Frame_Err=1, IDLE ignores S==0 until S seen 1 (no retrigger on stuck-low line).
//  No back-pressure: consumer must take word on o_Rx_DV; next frame overwrites.
//  Illegal parameter values (DATA_BITS, PARITY, STOP_BITS, CLKS_PER_BIT<4): elaboration error via generate check.
// CONFIGURATION
//  UART_RX_BREAK_DETECT_EN defined:
//   o_Break pulses with o_Rx_DV when data==0, parity sample 0 (if present) and all stop bits 0.
//   Frame still reported: o_Rx_Byte=0, o_Frame_Err=1.
//   Re-arm waits for line high as above.
//  UART_RX_BREAK_DETECT_EN undefined: o_Break tied 0; no break logic synthesised.
// TESTING (CLKS_PER_BIT=16 unless stated)
//  DATA_BITS=8, PARITY=2, STOP_BITS=1, send 0xA5, even parity 0
//    -> one o_Rx_DV; o_Rx_Byte=0xA5; both errors 0.
//  Same config, 0x3C sent with parity bit 1
//    -> o_Rx_DV; o_Rx_Byte=0x3C; o_Parity_Err=1; o_Frame_Err=0.
//  Line low for 4 clocks, then high -> no o_Rx_DV; o_Busy drops within 16 clocks.
//    1-clock glitch at C=M of a data bit -> bit value unchanged (majority).
//  0x55 with stop bit 0, line held low 100 bit times
//    -> one o_Rx_DV, o_Frame_Err=1; no further strobe until line high and a new start.
//    With UART_RX_BREAK_DETECT_EN, all-zero frame -> o_Break=1 coincident with o_Rx_DV.
//  DATA_BITS=7, PARITY=1, STOP_BITS=2; send 0x41 then 0x7F back-to-back
//    -> two strobes, correct words, no errors.
//    i_Reset_n=0 at DATA bit 3 -> no strobe; outputs 0.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg_if
// Connects the serial line and the word/status outputs of uart_rx_cfg to the
// logic that drives the pin and consumes received words.
//   i_Rx_Serial   serial line into the receiver, idle high
//   o_Rx_DV       1-cycle strobe: word and error flags valid
//   o_Rx_Byte     received word, held until the next strobe
//   o_Parity_Err  parity mismatch on the last word
//   o_Frame_Err   a stop bit of the last word was sampled 0
//   o_Busy        receiver is inside a frame
//   o_Break       break strobe (only when UART_RX_BREAK_DETECT_EN is defined)
// master: the receiver. slave: the pin driver / word consumer.
// -----------------------------------------------------------------------------
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Busy;
  logic                 o_Break;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Busy, o_Break
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Busy, o_Break
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised UART receiver with 3-sample majority voting per bit, optional
// parity, 1 or 2 stop bits. One word is reported per frame with its parity and
// framing error flags; there is no buffering or back-pressure.
// Optional feature macro: UART_RX_BREAK_DETECT_EN (break strobe on o_Break).
// Ports:
//   i_Clock    system clock, rising edge
//   i_Reset_n  synchronous active-low reset
//   rx_if      uart_rx_cfg_if.master: serial input and word/status outputs
// Parameters: CLKS_PER_BIT (>=4), DATA_BITS (5..9), PARITY (0 none, 1 odd,
//   2 even), STOP_BITS (1 or 2).
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           i_Clock,
  input  logic           i_Reset_n,
  uart_rx_cfg_if.master  rx_if
);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 ||
      PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_rx_cfg: illegal parameter combination");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  // Three sample points straddle mid-bit; the vote is taken on the third.
  localparam logic [CW-1:0] C_S0   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_S2   = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  state_t               state_q;
  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic                 samp0_q, samp1_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, frm_err_q;
  logic                 armed_q;
  logic                 rx_dv_q, par_err_out_q, frm_err_out_q, busy_q;
  logic [DATA_BITS-1:0] rx_byte_q;
  logic                 maj_d;
  logic                 par_exp_d;

  // Majority of the two stored samples and the current synchronised sample.
  always_comb begin
    maj_d = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);
  end

  // Parity bit value a correct transmitter would send for the stored word.
  always_comb begin
    par_exp_d = 1'b0;
    if (PARITY == 1) begin
      par_exp_d = ~(^shift_q);
    end else begin
      par_exp_d = ^shift_q;
    end
  end

  // Synchroniser, bit timing, frame FSM and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      cnt_q         <= {CW{1'b0}};
      bit_idx_q     <= {IW{1'b0}};
      stop_idx_q    <= 1'b0;
      samp0_q       <= 1'b0;
      samp1_q       <= 1'b0;
      shift_q       <= {DATA_BITS{1'b0}};
      par_err_q     <= 1'b0;
      frm_err_q     <= 1'b0;
      armed_q       <= 1'b1;
      rx_dv_q       <= 1'b0;
      rx_byte_q     <= {DATA_BITS{1'b0}};
      par_err_out_q <= 1'b0;
      frm_err_out_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync1_q <= rx_if.i_Rx_Serial;
      sync2_q <= sync1_q;
      rx_dv_q <= 1'b0;
      if (cnt_q == C_S0) samp0_q <= sync2_q;
      if (cnt_q == C_S1) samp1_q <= sync2_q;

      case (state_q)
        S_IDLE: begin
          cnt_q <= {CW{1'b0}};
          // After a framing error the line must be seen high before a new
          // start is accepted, so a stuck-low line cannot retrigger.
          if (sync2_q) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q    <= S_START;
            busy_q     <= 1'b1;
            bit_idx_q  <= {IW{1'b0}};
            stop_idx_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
          end
        end

        S_START: begin
          if (cnt_q == C_S2 && maj_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
          end else if (cnt_q == C_LAST) begin
            state_q <= S_DATA;
            cnt_q   <= {CW{1'b0}};
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_q == C_S2) shift_q[bit_idx_q] <= maj_d;
          if (cnt_q == C_LAST) begin
            cnt_q <= {CW{1'b0}};
            if (bit_idx_q == I_LAST) begin
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_PARITY: begin
          if (cnt_q == C_S2) par_err_q <= maj_d ^ par_exp_d;
          if (cnt_q == C_LAST) begin
            state_q <= S_STOP;
            cnt_q   <= {CW{1'b0}};
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          // The last stop bit is left at its vote point so a following start
          // edge right after it is not missed.
          if (cnt_q == C_S2) begin
            if (!maj_d) frm_err_q <= 1'b1;
            if (stop_idx_q == STOP_LAST) begin
              state_q <= S_CLEANUP;
              cnt_q   <= {CW{1'b0}};
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (cnt_q == C_LAST) begin
            stop_idx_q <= 1'b1;
            cnt_q      <= {CW{1'b0}};
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_CLEANUP: begin
          rx_dv_q       <= 1'b1;
          rx_byte_q     <= shift_q;
          par_err_out_q <= par_err_q;
          frm_err_out_q <= frm_err_q;
          armed_q       <= ~frm_err_q;
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= {CW{1'b0}};
        end
      endcase
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_zero_q, stop_zero_q, break_q;

  // Break = every sampled bit of the frame was 0 (data, parity, all stops).
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      par_zero_q  <= 1'b1;
      stop_zero_q <= 1'b1;
      break_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        par_zero_q  <= 1'b1;
        stop_zero_q <= 1'b1;
      end
      if (state_q == S_PARITY && cnt_q == C_S2) par_zero_q <= ~maj_d;
      if (state_q == S_STOP && cnt_q == C_S2 && maj_d) stop_zero_q <= 1'b0;
      break_q <= (state_q == S_CLEANUP) && (shift_q == {DATA_BITS{1'b0}}) &&
                 par_zero_q && stop_zero_q;
    end
  end

  assign rx_if.o_Break = break_q;
`else
  assign rx_if.o_Break = 1'b0;
`endif

  assign rx_if.o_Rx_DV      = rx_dv_q;
  assign rx_if.o_Rx_Byte    = rx_byte_q;
  assign rx_if.o_Parity_Err = par_err_out_q;
  assign rx_if.o_Frame_Err  = frm_err_out_q;
  assign rx_if.o_Busy       = busy_q;

endmodule
